// File: rtl/fifo_ctrl_ext.sv
// fifo_ctrl_ext: pointer and status controller for a FIFO that sits in an
// external register-file memory. It is used for the UART TX and RX buffers.
// The controller tracks occupancy and raises almost-full and almost-empty
// flags against thresholds that can be changed at runtime. It also keeps
// sticky overflow and underflow flags and supports a synchronous flush.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   flush        synchronous flush; empties the FIFO on the next edge
//   wr, rd       write / read requests
//   clr_err      clears the sticky error flags
//   af_th        almost-full threshold  (almost_full  = count >= af_th)
//   ae_th        almost-empty threshold (almost_empty = count <= ae_th)
//   wr_en        memory write strobe for an accepted write (combinational)
//   w_addr       memory write address (write pointer)
//   r_addr       memory read address (read pointer)
//   full, empty  registered occupancy flags
//   almost_full  registered threshold flag
//   almost_empty registered threshold flag
//   count        registered occupancy, 0..DEPTH
//   overflow     sticky: a write was rejected because the FIFO was full
//   underflow    sticky: a read was rejected because the FIFO was empty
module fifo_ctrl_ext #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  input  logic [ADDR_WIDTH:0]   af_th,
  input  logic [ADDR_WIDTH:0]   ae_th,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_next, rd_ptr_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  rd_acc, wr_acc, ovf_evt, unf_evt;

  // A write while full is accepted only when a read frees a slot in the same
  // cycle. A write while empty is always accepted, even when a read is also
  // requested; that read is rejected because there is nothing to read yet.
  always_comb begin
    rd_acc  = rd & ~empty & ~flush;
    wr_acc  = wr & ~flush & (~full | rd);
    ovf_evt = wr & full & ~rd & ~flush;
    unf_evt = rd & empty & ~flush;

    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Pointers wrap naturally modulo DEPTH.
      if (wr_acc) wr_ptr_next = wr_ptr + 1'b1;
      if (rd_acc) rd_ptr_next = rd_ptr + 1'b1;
      count_next = count + {{ADDR_WIDTH{1'b0}}, wr_acc}
                         - {{ADDR_WIDTH{1'b0}}, rd_acc};
    end
  end

  assign wr_en  = wr_acc;
  assign w_addr = wr_ptr;
  assign r_addr = rd_ptr;

  // The flags are computed from the next-state count, so they change on the
  // same edge as the pointers. The thresholds are sampled on every edge, so a
  // threshold change takes effect even when there is no traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= af_th);
      almost_empty <= (count_next <= ae_th);
      // An error event in the same cycle as clr_err wins; the flag stays set.
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_evt)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_ext.sv
// Testbench for fifo_ctrl_ext. It runs directed scenarios first, then
// randomized traffic. Every output is compared against a reference model
// that tracks occupancy as a plain integer.
module tb_fifo_ctrl_ext;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, flush, wr, rd, clr_err;
  logic [AW:0]   af_th, ae_th;
  logic          wr_en, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;

  fifo_ctrl_ext #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr(wr), .rd(rd),
    .clr_err(clr_err), .af_th(af_th), .ae_th(ae_th), .wr_en(wr_en),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int m_count, m_wp, m_rp;
  bit m_af, m_ae, m_ovf, m_unf;
  int cur_af, cur_ae;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wp = 0; m_rp = 0;
    m_af = 0; m_ae = 1; m_ovf = 0; m_unf = 0;
  endtask

  task automatic check_all();
    check("count",        int'(count),        m_count);
    check("full",         int'(full),         int'(m_count == DEPTH));
    check("empty",        int'(empty),        int'(m_count == 0));
    check("almost_full",  int'(almost_full),  int'(m_af));
    check("almost_empty", int'(almost_empty), int'(m_ae));
    check("overflow",     int'(overflow),     int'(m_ovf));
    check("underflow",    int'(underflow),    int'(m_unf));
    check("w_addr",       int'(w_addr),       m_wp);
    check("r_addr",       int'(r_addr),       m_rp);
  endtask

  // Drive one cycle of requests from the negedge, check wr_en before the
  // edge, advance the model at the edge and check all outputs at the next
  // negedge.
  task automatic step(input bit w, input bit r, input bit f, input bit c);
    bit acc_w, acc_r, ovf, unf;
    wr = w; rd = r; flush = f; clr_err = c;
    af_th = (AW + 1)'(cur_af);
    ae_th = (AW + 1)'(cur_ae);
    acc_r = r && !f && (m_count > 0);
    acc_w = w && !f && (m_count < DEPTH || r);
    ovf   = w && !r && !f && (m_count == DEPTH);
    unf   = r && !f && (m_count == 0);
    #1;
    check("wr_en", int'(wr_en), int'(acc_w));
    @(posedge clk);
    if (f) begin
      m_count = 0; m_wp = 0; m_rp = 0;
    end else begin
      m_count = m_count + int'(acc_w) - int'(acc_r);
      m_wp = (m_wp + int'(acc_w)) % DEPTH;
      m_rp = (m_rp + int'(acc_r)) % DEPTH;
    end
    m_af = (m_count >= cur_af);
    m_ae = (m_count <= cur_ae);
    if (ovf) m_ovf = 1; else if (c) m_ovf = 0;
    if (unf) m_unf = 1; else if (c) m_unf = 0;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; flush = 0; wr = 0; rd = 0; clr_err = 0;
    cur_af = 12; cur_ae = 2;
    af_th = 5'd12; ae_th = 5'd2;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;
    @(negedge clk);
    check_all();

    // Fill to full with no reads; the write pointer wraps back to 0.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    // Write while full is rejected and sets overflow.
    step(1, 0, 0, 0);
    // Write plus read while full keeps the FIFO full and moves both pointers.
    step(1, 1, 0, 0);
    // Drain to empty.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    // Write plus read while empty: the write lands and the read underflows.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);

    // Load five entries, flush with a pending write, then clear the errors.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 1);

    // Threshold behaviour.
    cur_ae = 2; cur_af = 14;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    cur_ae = 4;
    step(0, 0, 0, 0);

    // Asynchronous reset in the middle of traffic, at a count of 7.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    wr = 0; rd = 0; flush = 0; clr_err = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit w, r, f, c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 3) cur_af = $urandom_range(0, DEPTH);
      if ($urandom_range(0, 99) < 3) cur_ae = $urandom_range(0, DEPTH);
      // Some bursts in one direction, so the FIFO reaches the full and
      // empty boundaries.
      if ((i / 200) % 3 == 1) w = ($urandom_range(0, 99) < 85);
      if ((i / 200) % 3 == 2) r = ($urandom_range(0, 99) < 85);
      step(w, r, f, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_ext.md
Name: fifo_ctrl_ext

Overview:
Parametrised FIFO pointer/status controller for the UART TX/RX buffers; drives an external register-file memory via write enable and read/write addresses. Successor to the basic controller. Adds:
- occupancy count and runtime-programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- corrected simultaneous read/write handling at the empty and full boundaries

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries (default 16)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush; empties FIFO
wr  in  1  write request
rd  in  1  read request
clr_err  in  1  clears sticky error flags
af_th  in  ADDR_WIDTH+1  almost-full threshold (count >= af_th)
ae_th  in  ADDR_WIDTH+1  almost-empty threshold (count <= ae_th)
wr_en  out  1  memory write strobe (accepted write), combinational
w_addr  out  ADDR_WIDTH  write address = wr_ptr
r_addr  out  ADDR_WIDTH  read address = rd_ptr
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  registered threshold flag
almost_empty  out  1  registered threshold flag
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected

Behaviour:
- Reset values (async): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- All status outputs are registered and are computed from next-state values, so they are valid in the same cycle the pointers update. There is no extra flag latency.

Acceptance (combinational, from current registered state):
- rd_acc = rd & ~empty & ~flush
- wr_acc = wr & ~flush & (~full | rd)
- A write while full is accepted only when a read frees a slot in the same cycle.
- wr & rd while empty: write accepted, read rejected, count becomes 1. The write is never dropped.
- wr_en = wr_acc. Memory writes data at w_addr on that edge.

Pointers:
- On wr_acc, wr_ptr+1; on rd_acc, rd_ptr+1.
- Natural wrap modulo DEPTH (DEPTH-1 -> 0).

Count and flags:
- count_next = count + wr_acc - rd_acc, computed in ADDR_WIDTH+1 bits; never exceeds DEPTH and never goes below 0.
- full = (count_next == DEPTH); empty = (count_next == 0).
- almost_full = (count_next >= af_th); almost_empty = (count_next <= ae_th).
- Threshold inputs are sampled every cycle; a threshold change takes effect at the next edge even with no traffic.

Flush:
- flush has priority over wr/rd.
- Next edge: pointers=0, count=0, empty=1, full=0, thresholds re-evaluated against 0.
- Sticky flags are not affected by flush.

Errors:
- ovf_evt = wr & full & ~rd & ~flush
- unf_evt = rd & empty & ~flush
- Each event sets its sticky flag.
- clr_err clears both flags; an event in the same cycle as clr_err wins (flag stays 1).
- Rejected operations leave all pointers and count unchanged.

Reset mid-operation:
- Asynchronous return to reset values; any in-flight wr_en is discarded (memory contents are don't-care).

Test Plan:
1. Reset, then 16 writes with no reads -> count 1..16; full=1 after the 16th edge; w_addr wraps 15->0; almost_full=1 from count>=af_th (af_th=12: asserted after the 12th write).
2. With the FIFO full, wr=1 rd=0 -> wr_en=0, overflow=1, count stays 16. Then wr=1 rd=1 -> wr_en=1, both pointers advance, count stays 16, full stays 1.
3. With the FIFO empty, wr=1 rd=1 -> wr_en=1, rd_ptr unchanged, count=1, empty=0, underflow=1. Next cycle rd=1 -> count=0, empty=1.
4. Load 5 entries, assert flush with wr=1 -> wr_en=0; next edge count=0, empty=1, w_addr=r_addr=0; previously set overflow stays 1. clr_err=1 with no event -> overflow=0.
5. Set ae_th=2, af_th=14. Fill to 3 and drain -> almost_empty goes 0->1 when count becomes 2. Raise ae_th to 4 at count=3 with no traffic -> almost_empty=1 on the next edge.
6. Assert reset asynchronously mid-stream at count=7 -> outputs take reset values immediately, before the clock edge. After release, one write gives count=1, w_addr=1.
